// File: rtl/mux4_pkg.sv
// Shared types and sizes for the 4:1 mux round-robin select controller.
package mux4_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first requester after base, wrapping,
// so base itself is chosen only when it is the sole requester.
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] base,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        any  = |req;
        idx  = base;
        cand = base;
        for (int i = N_CH; i >= 1; i--) begin
            cand = base + SEL_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_select_ctrl.sv
// Round-robin select controller driving a 4:1 mux sel with a
// valid/ready qualified output and a per-grant beat limit.
module mux4_rr_select_ctrl
    import mux4_pkg::*;
#(
    parameter int MAX_BEATS = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  grant,
    output logic             out_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    state_t           state, state_n;
    logic [SEL_W-1:0] last_ptr, last_n;
    logic [SEL_W-1:0] sel_n;
    logic [N_CH-1:0]  grant_n;
    logic [CNT_W-1:0] beat_cnt, cnt_n;
    logic [SEL_W-1:0] pick_base, pick_idx;
    logic             pick_any;
    logic             fire;
    logic             last_beat;
    logic             rel;

    assign busy      = (state == GRANT);
    assign out_valid = busy && req[sel];
    assign fire      = out_valid && out_ready;
    assign last_beat = (beat_cnt == CNT_W'(MAX_BEATS - 1));

    // On release the channel just served becomes the new base.
    assign pick_base = busy ? sel : last_ptr;

    rr_pick4 u_pick (
        .req  (req),
        .base (pick_base),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        state_n = state;
        sel_n   = sel;
        grant_n = grant;
        last_n  = last_ptr;
        cnt_n   = beat_cnt;
        rel     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    sel_n   = pick_idx;
                    grant_n = N_CH'(1) << pick_idx;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    rel = 1'b1;
                end else if (fire && last_beat) begin
                    rel = 1'b1;
                end else if (fire) begin
                    cnt_n = beat_cnt + CNT_W'(1);
                end
                if (rel) begin
                    last_n = sel;
                    cnt_n  = '0;
                    if (pick_any) begin
                        sel_n   = pick_idx;
                        grant_n = N_CH'(1) << pick_idx;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            grant    <= '0;
            last_ptr <= SEL_W'(N_CH - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            grant    <= grant_n;
            last_ptr <= last_n;
            beat_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_mux4_rr_select_ctrl.sv
// Directed bench for mux4_rr_select_ctrl: MAX_BEATS=4 and MAX_BEATS=1
// instances share clock, reset and request inputs.
module tb_mux4_rr_select_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;

    logic [1:0] sel4, sel1;
    logic [3:0] grant4, grant1;
    logic       ov4, ov1, busy4, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_rr_select_ctrl #(.MAX_BEATS(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel4),
        .grant     (grant4),
        .out_valid (ov4),
        .busy      (busy4)
    );

    mux4_rr_select_ctrl #(.MAX_BEATS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel1),
        .grant     (grant1),
        .out_valid (ov1),
        .busy      (busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({sel4, grant4, ov4, busy4} !== 8'b00_0000_0_0) begin
            errors++;
            $display("FAIL reset_dut4 got sel=%b grant=%b ov=%b busy=%b want 00 0000 0 0",
                     sel4, grant4, ov4, busy4);
        end
        step();
        checks++;
        if ({sel1, grant1, ov1, busy1} !== 8'b00_0000_0_0) begin
            errors++;
            $display("FAIL reset_dut1 got sel=%b grant=%b ov=%b busy=%b want 00 0000 0 0",
                     sel1, grant1, ov1, busy1);
        end
        checks++;
        if (dut4.last_ptr !== 2'b11) begin
            errors++;
            $display("FAIL reset_last_ptr got %b want 11", dut4.last_ptr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sole_requester();
        logic [2:0] exp_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
        do_reset();
        req       = 4'b0100;
        out_ready = 1'b1;
        step();
        checks++;
        if ({grant4, sel4, ov4} !== 7'b0100_10_1) begin
            errors++;
            $display("FAIL sole_first_grant got grant=%b sel=%b ov=%b want 0100 10 1",
                     grant4, sel4, ov4);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({dut4.beat_cnt, grant4, busy4} !== {exp_cnt[i], 4'b0100, 1'b1}) begin
                errors++;
                $display("FAIL sole_beat%0d got cnt=%0d grant=%b busy=%b want %0d 0100 1",
                         i, dut4.beat_cnt, grant4, busy4, exp_cnt[i]);
            end
        end
        checks++;
        if (dut4.last_ptr !== 2'b10) begin
            errors++;
            $display("FAIL sole_regrant_last_ptr got %b want 10", dut4.last_ptr);
        end
    endtask

    task automatic test_rotate_max1();
        logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({sel1, grant1} !== {exp_sel[i], 4'b0001 << exp_sel[i]}) begin
                errors++;
                $display("FAIL rotate_step%0d got sel=%b grant=%b want sel=%b",
                         i, sel1, grant1, exp_sel[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
        do_reset();
        req       = 4'b0001;
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({grant4, dut4.beat_cnt, ov4} !== {4'b0001, 3'd0, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold%0d got grant=%b cnt=%0d ov=%b want 0001 0 1",
                         i, grant4, dut4.beat_cnt, ov4);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (dut4.beat_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL bp_beat%0d got cnt=%0d want %0d",
                         i, dut4.beat_cnt, exp_cnt[i]);
            end
        end
        checks++;
        if ({dut4.last_ptr, grant4} !== 6'b00_0001) begin
            errors++;
            $display("FAIL bp_release got last_ptr=%b grant=%b want 00 0001",
                     dut4.last_ptr, grant4);
        end
    endtask

    task automatic test_drop_req();
        do_reset();
        req       = 4'b0011;
        out_ready = 1'b1;
        step();
        checks++;
        if ({grant4, sel4} !== 6'b0001_00) begin
            errors++;
            $display("FAIL drop_first got grant=%b sel=%b want 0001 00", grant4, sel4);
        end
        step();
        step();
        checks++;
        if (dut4.beat_cnt !== 3'd2) begin
            errors++;
            $display("FAIL drop_two_beats got cnt=%0d want 2", dut4.beat_cnt);
        end
        req = 4'b0010;
        #1;
        checks++;
        if (ov4 !== 1'b0) begin
            errors++;
            $display("FAIL drop_valid_low got ov=%b want 0", ov4);
        end
        step();
        checks++;
        if ({grant4, sel4, ov4} !== 7'b0010_01_1) begin
            errors++;
            $display("FAIL drop_switch got grant=%b sel=%b ov=%b want 0010 01 1",
                     grant4, sel4, ov4);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req       = 4'b0100;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if ({grant4, busy4} !== 5'b0100_1) begin
            errors++;
            $display("FAIL arst_pre got grant=%b busy=%b want 0100 1", grant4, busy4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel4, grant4, ov4, busy4} !== 8'b00_0000_0_0) begin
            errors++;
            $display("FAIL arst_clear got sel=%b grant=%b ov=%b busy=%b want 00 0000 0 0",
                     sel4, grant4, ov4, busy4);
        end
        req = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({grant4, sel4} !== 6'b0010_01) begin
            errors++;
            $display("FAIL arst_restart got grant=%b sel=%b want 0010 01", grant4, sel4);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;
        test_reset();
        test_sole_requester();
        test_rotate_max1();
        test_backpressure();
        test_drop_req();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
